// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-digit blank/drive slots, PWM brightness,
// registered outputs. Optional leading-zero blanking is enabled by defining DISP_SCAN_LZB_EN.
module disp_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int BLANK_CYC  = 16,
   localparam int AW        = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [4:0]            wr_data,
   input  logic [2:0]            bright,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  frame_tick
);

   // Counter is at least 3 bits wide so the PWM phase bits always exist.
   localparam int CW = ($clog2(SCAN_DIV) < 3) ? 3 : $clog2(SCAN_DIV);

   typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
   logic [AW-1:0]         dig_idx_q, dig_idx_d;
   logic [4:0]            digits_q [NUM_DIGITS];
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
   logic                  frame_tick_q, frame_tick_d;

   logic       slot_last_s, blank_last_s, idx_last_s, pwm_on_s, wr_ok_s, blank_cur_s;
   logic [4:0] cur_digit_s;
   logic [6:0] cur_seg_s;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         4'hF:    s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign slot_last_s  = (slot_cnt_q == CW'(SCAN_DIV - 1));
   assign blank_last_s = (slot_cnt_q == CW'(BLANK_CYC - 1));
   assign idx_last_s   = (dig_idx_q == AW'(NUM_DIGITS - 1));
   assign pwm_on_s     = (slot_cnt_q[2:0] <= bright);
   assign wr_ok_s      = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS));
   assign cur_digit_s  = digits_q[dig_idx_q];
   assign cur_seg_s    = blank_cur_s ? 7'h00 : hex_to_seg(cur_digit_s[3:0]);

`ifdef DISP_SCAN_LZB_EN
   logic                  zero_above_s;
   logic [NUM_DIGITS-1:0] lzb_mask_s;

   // A digit is blanked when it and every higher digit hold zero; digit 0 always shows.
   always_comb begin
      zero_above_s = 1'b1;
      lzb_mask_s   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above_s  = zero_above_s && (digits_q[i][3:0] == 4'd0);
         lzb_mask_s[i] = zero_above_s;
      end
   end

   assign blank_cur_s = lzb_mask_s[dig_idx_q];
`else
   assign blank_cur_s = 1'b0;
`endif

   // Next-state and next-output logic; ena low freezes the scan and darkens the outputs.
   always_comb begin
      state_d      = state_q;
      slot_cnt_d   = slot_cnt_q;
      dig_idx_d    = dig_idx_q;
      seg_d        = 7'h00;
      dp_d         = 1'b0;
      dig_sel_d    = '0;
      frame_tick_d = 1'b0;
      if (ena) begin
         case (state_q)
            ST_BLANK: begin
               if (blank_last_s) state_d = ST_DRIVE;
               else              state_d = ST_BLANK;
            end
            ST_DRIVE: begin
               dig_sel_d = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << dig_idx_q;
               if (pwm_on_s) begin
                  seg_d = cur_seg_s;
                  dp_d  = cur_digit_s[4];
               end else begin
                  seg_d = 7'h00;
                  dp_d  = 1'b0;
               end
               if (slot_last_s) state_d = ST_BLANK;
               else             state_d = ST_DRIVE;
            end
            default: state_d = ST_BLANK;
         endcase
         if (slot_last_s) begin
            slot_cnt_d   = '0;
            dig_idx_d    = idx_last_s ? '0 : dig_idx_q + AW'(1);
            frame_tick_d = idx_last_s;
         end else begin
            slot_cnt_d   = slot_cnt_q + CW'(1);
         end
      end else begin
         state_d = state_q;
      end
   end

   // Scan state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_BLANK;
         slot_cnt_q   <= '0;
         dig_idx_q    <= '0;
         seg_q        <= 7'h00;
         dp_q         <= 1'b0;
         dig_sel_q    <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_cnt_q   <= slot_cnt_d;
         dig_idx_q    <= dig_idx_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         dig_sel_q    <= dig_sel_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   // Digit registers accept writes regardless of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '{default: 5'd0};
      end else if (wr_ok_s) begin
         digits_q[wr_addr] <= wr_data;
      end else begin
         digits_q <= digits_q;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign dig_sel    = dig_sel_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: arithmetic reference model compared every cycle,
// directed literal checks from the test plan, then randomized traffic with occasional resets.
module tb_disp_scan_ctrl;
   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int FRAME = ND * SD;

   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic       clk, rst_n, ena, wr_en;
   logic [1:0] wr_addr;
   logic [4:0] wr_data;
   logic [2:0] bright;
   logic [6:0] seg;
   logic       dp, frame_tick;
   logic [3:0] dig_sel;

   logic       wr_en6;
   logic [2:0] wr_addr6;
   logic [4:0] wr_data6;
   logic [6:0] seg6;
   logic       dp6, frame_tick6;
   logic [5:0] dig_sel6;

   int n_vec = 0;
   int n_err = 0;

   disp_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .bright(bright), .seg(seg), .dp(dp), .dig_sel(dig_sel),
      .frame_tick(frame_tick));

   disp_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(SD), .BLANK_CYC(BC)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en6), .wr_addr(wr_addr6),
      .wr_data(wr_data6), .bright(bright), .seg(seg6), .dp(dp6), .dig_sel(dig_sel6),
      .frame_tick(frame_tick6));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: m_t counts enabled edges since reset; slot/digit follow by arithmetic.
   int unsigned      m_t;
   logic [3:0][4:0]  m_regs;
   logic [6:0]       e_seg;
   logic             e_dp, e_ft;
   logic [3:0]       e_sel;

   function automatic logic lit(int unsigned t, logic [2:0] br);
      int unsigned s;
      s = t % SD;
      return (s >= BC) && ((s % 8) <= 32'(br));
   endfunction

   function automatic logic [6:0] f_seg(int unsigned t, logic [3:0][4:0] r, logic [2:0] br);
      int unsigned d;
      d = (t / SD) % ND;
      if (!lit(t, br)) return 7'h00;
`ifdef DISP_SCAN_LZB_EN
      begin
         int hmax;
         hmax = -1;
         for (int j = 0; j < ND; j++) if (r[j][3:0] != 4'd0) hmax = j;
         if (d != 0 && int'(d) > hmax) return 7'h00;
      end
`endif
      return FONT[r[d][3:0]];
   endfunction

   function automatic logic f_dp(int unsigned t, logic [3:0][4:0] r, logic [2:0] br);
      if (!lit(t, br)) return 1'b0;
      return r[(t / SD) % ND][4];
   endfunction

   function automatic logic [3:0] f_sel(int unsigned t);
      if ((t % SD) < BC) return 4'b0000;
      return 4'b0001 << ((t / SD) % ND);
   endfunction

   initial begin
      m_t = 0; m_regs = '0; e_seg = 7'h00; e_dp = 1'b0; e_sel = 4'h0; e_ft = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_t = 0; m_regs = '0; e_seg = 7'h00; e_dp = 1'b0; e_sel = 4'h0; e_ft = 1'b0;
         end else begin
            if (ena) begin
               e_seg = f_seg(m_t, m_regs, bright);
               e_dp  = f_dp(m_t, m_regs, bright);
               e_sel = f_sel(m_t);
               e_ft  = ((m_t % FRAME) == FRAME - 1);
               m_t   = m_t + 1;
            end else begin
               e_seg = 7'h00; e_dp = 1'b0; e_sel = 4'h0; e_ft = 1'b0;
            end
            if (wr_en) m_regs[wr_addr] = wr_data;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      n_vec++;
      if (seg !== e_seg || dp !== e_dp || dig_sel !== e_sel || frame_tick !== e_ft) begin
         n_err++;
         $display("FAIL cycle t=%0t seg/dp/sel/ft got %h/%b/%b/%b expected %h/%b/%b/%b",
                  $time, seg, dp, dig_sel, frame_tick, e_seg, e_dp, e_sel, e_ft);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic goto(input int unsigned pos);
      for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != pos; i++) tick();
      chk("goto_bound", m_t % FRAME, pos);
   endtask

   initial begin
      int       cnt, first, idx;
      logic [6:0] e;
      rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 5'd0; bright = 3'd7;
      wr_en6 = 1'b0; wr_addr6 = 3'd0; wr_data6 = 5'd0;
      tick(); tick(); tick();
      chk("reset_outputs", {seg, dp, dig_sel, frame_tick}, 32'd0);
      rst_n = 1'b1;

      // Slot timing and frame period.
      cnt = 0; first = 0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k <= 11)
            chk("dig_sel_seq", dig_sel, (k >= 3 && k <= 8) ? 32'd1 : (k == 11) ? 32'd2 : 32'd0);
         if (frame_tick) begin cnt++; if (first == 0) first = k; end
      end
      chk("frame_first", first, 32'd32);
      chk("frame_count", cnt, 32'd2);

      // Writes, and a mid-DRIVE rewrite visible one edge later.
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h13; tick(); wr_en = 1'b0;
      goto(11); tick();
      chk("d1_seg3", seg, 32'h4F); chk("d1_dp", dp, 32'd1); chk("d1_sel", dig_sel, 32'd2);
      wr_en = 1'b1; wr_data = 5'h08; tick(); wr_en = 1'b0;
      chk("d1_old_seg", seg, 32'h4F);
      tick();
      chk("d1_new_seg", seg, 32'h7F); chk("d1_new_dp", dp, 32'd0);

      // PWM: bright=0 darkens all drive slots, bright=3 lights slots 2,3 only.
      for (int b = 0; b < 2; b++) begin
         bright = (b == 0) ? 3'd0 : 3'd3;
         goto(8);
         cnt = 0; first = 0;
         for (int k = 0; k < SD; k++) begin
            tick();
            if (dig_sel == 4'b0010) cnt++;
            if (seg != 7'h00) first++;
         end
         chk("pwm_sel_len", cnt, 32'd6);
         chk("pwm_lit", first, (b == 0) ? 32'd0 : 32'd2);
      end
      bright = 3'd7;

      // Pause mid-DRIVE; the slot resumes where it stopped.
      goto(10); tick(); tick();
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("pause_out", {seg, dp, dig_sel, frame_tick}, 32'd0);
      end
      ena = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (dig_sel == 4'b0010) cnt++;
         else break;
      end
      chk("resume_drive", cnt, 32'd4);

      // Leading-zero case: regs {0,0,5,0}.
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h05; tick();
      wr_addr = 2'd0; wr_data = 5'h00; tick(); wr_en = 1'b0;
      goto(2);  tick(); chk("lz_d0", seg, 32'h3F);
      goto(10); tick(); chk("lz_d1", seg, 32'h6D);
`ifdef DISP_SCAN_LZB_EN
      e = 7'h00;
`else
      e = 7'h3F;
`endif
      goto(18); tick(); chk("lz_d2", seg, 32'(e));
      goto(26); tick(); chk("lz_d3", seg, 32'(e));

      // Out-of-range addresses on a 6-digit instance are ignored.
      wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 5'h1F; tick();
      wr_addr6 = 3'd6; tick();
      wr_addr6 = 3'd5; wr_data6 = 5'h08; tick(); wr_en6 = 1'b0;
      cnt = 0;
      for (int k = 0; k < 48; k++) begin
         tick();
         if (dig_sel6 != 6'd0) begin
            cnt++;
            idx = 0;
            for (int j = 0; j < 6; j++) if (dig_sel6[j]) idx = j;
            chk("d6_seg", seg6, (idx == 5) ? 32'h7F : 32'h3F);
            chk("d6_dp", dp6, 32'd0);
         end
      end
      chk("d6_drive_len", cnt, 32'd36);

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst_n   = ($urandom_range(0, 499) != 0);
         ena     = ($urandom_range(0, 9) != 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 49) == 0) bright = 3'($urandom_range(0, 7));
         tick();
      end
      rst_n = 1'b1;
      ena = 1'b1;
      wr_en = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the multi-digit 7-segment display driven by tt_um_disp1. It holds one hex nibble plus decimal point per digit and cycles through the digits. Each digit slot has a dead-time blanking phase followed by a drive phase, with brightness set by PWM. It sits between the ui_in/uio_in write path and the uo_out/uio_out pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8); AW = $clog2(NUM_DIGITS).
- SCAN_DIV, 1000, clocks per digit slot (SCAN_DIV > BLANK_CYC).
- BLANK_CYC, 16, dead-time clocks at the start of each slot (>= 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  run enable; low freezes the scan
- wr_en  in  1  digit-register write strobe
- wr_addr  in  AW  digit index to write
- wr_data  in  5  [4]=dp, [3:0]=hex value
- bright  in  3  brightness, 0 = 1/8 duty up to 7 = full duty
- seg  out  7  segments a..g, seg[0]=a, active high
- dp  out  1  decimal point, active high
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active high
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async, rst_n=0):
  - all digit registers = 0; dig_idx = 0; slot_cnt = 0; state = BLANK.
  - seg = 0, dp = 0, dig_sel = 0, frame_tick = 0.
- All outputs are registered and reflect internal state from the previous edge.
- slot_cnt runs 0..SCAN_DIV-1 while ena=1.
  - BLANK while slot_cnt < BLANK_CYC: seg = 0, dp = 0, dig_sel = 0.
  - DRIVE for slot_cnt BLANK_CYC..SCAN_DIV-1: dig_sel = one-hot(dig_idx).
  - In DRIVE, seg and dp are the decoded digit gated by PWM: on when slot_cnt[2:0] <= bright, else 0.
  - dig_sel stays asserted for the whole DRIVE phase regardless of PWM.
- Slot end (slot_cnt = SCAN_DIV-1):
  - slot_cnt -> 0, state -> BLANK, dig_idx increments.
  - When dig_idx = NUM_DIGITS-1 it wraps to 0 and frame_tick = 1 for exactly that one following cycle.
- Decoder: standard hex 0-F on segments a..g, e.g. 0 = 0x3F, 1 = 0x06, 8 = 0x7F, A = 0x77, F = 0x71.
- Writes:
  - wr_en=1 at edge N loads reg[wr_addr].
  - If that digit is in the lit DRIVE phase, the new pattern appears on seg at edge N+1.
  - wr_addr >= NUM_DIGITS is ignored.
  - Writes are accepted even when ena=0.
- ena=0:
  - slot_cnt, dig_idx and state hold.
  - seg, dp, dig_sel and frame_tick are forced to 0 at the next edge.
  - When ena returns to 1, the scan resumes from the held slot_cnt.
- Reset mid-slot aborts immediately to the reset state; there is no partial-slot completion.
- A write and a slot wrap in the same cycle are independent; both take effect.

Optional Feature:
- Macro: DISP_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Any digit whose index is above the highest-index digit holding a nonzero hex value shows seg = 0; its dp is still driven.
  - Digit 0 is never blanked.
  - dig_sel timing is unchanged.
- Undefined: every digit decodes normally, zeros included.

Test Plan:
- Params NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 in all tests.
- Reset, ena=1, bright=7: dig_sel=0 for 2 cycles, then 4'b0001 for 6 cycles, then 0 for 2 cycles, then 4'b0010. frame_tick pulses once every 32 cycles.
- Write 0x13 (dp=1, value 3) to addr 1, bright=7: during digit 1 DRIVE, seg=0x4F and dp=1. Write 0x08 to addr 1 mid-DRIVE: seg=0x7F one cycle later.
- bright=0: in each DRIVE phase seg is nonzero only when slot_cnt[2:0]=0. dig_sel stays high for the full 6 cycles.
- Drop ena for 5 cycles mid-DRIVE: all outputs are 0 from the next edge. On ena=1, the remaining DRIVE cycles complete and the slot length excluding the pause is still 8. A write to addr 7 leaves all registers unchanged.
- With DISP_SCAN_LZB_EN, regs = {0,0,5,0} (addr3..0): digits 3 and 2 show seg=0, digit 1 shows 0x6D, digit 0 shows 0x3F. Without the macro, digit 3 and digit 2 both show 0x3F.
